jam_cost_table: RTL and testbench

//  Upstream cost source for the JAM job-assignment solver. Loads an 8x8 worker/job

---
 rtl/jam_cost_table.sv | 81 ++++++++
 tb/tb_jam_cost_table.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jam_cost_table.sv
// jam_cost_table: loads an 8x8 cost matrix over a valid/ready stream, serves registered
// (w,j) lookups and accumulates the sum of row minima as a lower bound.
module jam_cost_table #(
    parameter int N_DIM   = 8,
    parameter int COST_W  = 7,
    parameter int BOUND_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COST_W-1:0]  in_data,
    input  logic [2:0]         w,
    input  logic [2:0]         j,
    output logic [COST_W-1:0]  cost,
    output logic               table_ready,
    output logic [BOUND_W-1:0] lower_bound
);
    localparam int IW = $clog2(N_DIM);
    localparam int KW = 2 * IW;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t              state, state_next;
    logic [KW-1:0]       k;
    logic [COST_W-1:0]   row_min, row_min_new;
    logic [BOUND_W-1:0]  bound;
    logic                accept, row_end;
    logic [COST_W-1:0]   mem [N_DIM*N_DIM];

    // a beat coinciding with load_start is dropped
    assign accept      = in_valid & in_ready & ~load_start;
    assign row_end     = k[IW-1:0] == '1;
    assign row_min_new = (in_data < row_min) ? in_data : row_min;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = (state == IDLE || load_start) ? LOAD :
                     (accept && k == '1)           ? READY : state;
    end

    always_comb begin
        in_ready    = state == LOAD;
        table_ready = state == READY;
        lower_bound = table_ready ? bound : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            row_min <= '1;
            bound   <= '0;
            cost    <= '0;
        end else if (load_start) begin
            k       <= '0;
            row_min <= '1;
            bound   <= '0;
            cost    <= '0;
        end else begin
            cost <= (state == READY) ? mem[{w, j}] : '0;
            if (accept) begin
                k       <= k + 1'b1;
                row_min <= row_end ? '1 : row_min_new;
                if (row_end)
                    bound <= bound + BOUND_W'(row_min_new);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[k] <= in_data;
    end
endmodule

// File: tb/tb_jam_cost_table.sv
// tb_jam_cost_table: randomized self-checking bench; the reference holds the matrix in an
// array and derives the bound as a plain sum of row minima.
module tb_jam_cost_table;
    logic       clk = 0, rst_n = 0, load_start = 0, in_valid = 0;
    logic [6:0] in_data = 0;
    logic [2:0] w = 0, j = 0;
    logic       in_ready, table_ready;
    logic [6:0] cost;
    logic [9:0] lower_bound;
    int checks = 0, failures = 0;
    int ref_mem [64];

    always #5 clk = ~clk;

    jam_cost_table dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .w(w), .j(j), .cost(cost),
        .table_ready(table_ready), .lower_bound(lower_bound)
    );

    function automatic int ref_bound();
        int s = 0;
        for (int r = 0; r < 8; r++) begin
            int m = 127;
            for (int c = 0; c < 8; c++)
                if (ref_mem[r*8+c] < m) m = ref_mem[r*8+c];
            s += m;
        end
        return s;
    endfunction

    task automatic send(input int d);
        int n = 0;
        in_valid = 1;
        in_data  = 7'(d);
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout in_ready=%0d required=1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic start_load();
        load_start = 1;
        @(posedge clk);
        #1 load_start = 0;
        checks++;
        if (table_ready !== 1'b0 || lower_bound !== 10'd0 || cost !== 7'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_load tr=%0d lb=%0d cost=%0d rdy=%0d required 0/0/0/1",
                     table_ready, lower_bound, cost, in_ready);
        end
    endtask

    task automatic load_table(input int gap_mode);
        for (int k = 0; k < 64; k++) begin
            if (k == 63) begin
                checks++;
                if (table_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL early_ready k=%0d table_ready=%0d required=0", k, table_ready);
                end
            end
            if (k == 32) begin
                checks++;
                if (cost !== 7'd0) begin
                    failures++;
                    $display("FAIL cost_in_load got=%0d required=0", cost);
                end
            end
            send(ref_mem[k]);
            if (gap_mode != 0) begin
                int g = (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        checks++;
        if (table_ready !== 1'b1 || in_ready !== 1'b0 || lower_bound !== 10'(ref_bound())) begin
            failures++;
            $display("FAIL load_done tr=%0d rdy=%0d lb=%0d required 1/0/%0d",
                     table_ready, in_ready, lower_bound, ref_bound());
        end
    endtask

    task automatic lookup(input int wi, input int ji);
        w = 3'(wi);
        j = 3'(ji);
        @(posedge clk);
        #1;
        checks++;
        if (cost !== 7'(ref_mem[wi*8+ji])) begin
            failures++;
            $display("FAIL lookup w=%0d j=%0d got=%0d required=%0d", wi, ji, cost, ref_mem[wi*8+ji]);
        end
    endtask

    task automatic sweep();
        int perm [64];
        for (int i = 0; i < 64; i++) perm[i] = i;
        for (int i = 63; i > 0; i--) begin
            int r = int'($urandom_range(0, i));
            int t = perm[i];
            perm[i] = perm[r];
            perm[r] = t;
        end
        for (int i = 0; i < 64; i++) lookup(perm[i] / 8, perm[i] % 8);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (in_ready !== 1'b0 || cost !== 7'd0 || table_ready !== 1'b0 || lower_bound !== 10'd0) begin
            failures++;
            $display("FAIL reset rdy=%0d cost=%0d tr=%0d lb=%0d required all 0",
                     in_ready, cost, table_ready, lower_bound);
        end
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_seq_load();
        for (int k = 0; k < 64; k++) ref_mem[k] = k;
        load_table(0);
        checks++;
        if (lower_bound !== 10'd224) begin
            failures++;
            $display("FAIL seq_bound got=%0d required=224", lower_bound);
        end
    endtask

    task automatic test_lookup();
        lookup(3, 5);
        checks++;
        if (cost !== 7'd29) begin
            failures++;
            $display("FAIL lookup_3_5 got=%0d required=29", cost);
        end
        sweep();
    endtask

    task automatic test_toggle();
        start_load();
        for (int k = 0; k < 64; k++) ref_mem[k] = 100;
        load_table(1);
        in_valid = 1;
        in_data  = 7'd5;
        repeat (3) @(posedge clk);
        #1 in_valid = 0;
        checks++;
        if (lower_bound !== 10'd800 || table_ready !== 1'b1) begin
            failures++;
            $display("FAIL toggle_bound lb=%0d tr=%0d required 800/1", lower_bound, table_ready);
        end
        lookup(0, 0);
        lookup(7, 7);
    endtask

    task automatic test_row2();
        int row2 [8] = '{90, 12, 127, 5, 44, 5, 60, 70};
        start_load();
        for (int k = 0; k < 64; k++) ref_mem[k] = (k / 8 == 2) ? row2[k%8] : 127;
        load_table(0);
        checks++;
        if (lower_bound !== 10'd894) begin
            failures++;
            $display("FAIL row2_bound got=%0d required=894", lower_bound);
        end
        lookup(2, 3);
    endtask

    task automatic test_restart();
        start_load();
        for (int k = 0; k < 20; k++) send(int'($urandom_range(0, 127)));
        load_start = 1;
        in_valid   = 1;
        in_data    = 7'd77;
        @(posedge clk);
        #1;
        load_start = 0;
        in_valid   = 0;
        checks++;
        if (table_ready !== 1'b0 || in_ready !== 1'b1 || lower_bound !== 10'd0) begin
            failures++;
            $display("FAIL restart tr=%0d rdy=%0d lb=%0d required 0/1/0", table_ready, in_ready, lower_bound);
        end
        for (int k = 0; k < 64; k++) ref_mem[k] = int'($urandom_range(0, 127));
        load_table(2);
        sweep();
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        checks++;
        if (table_ready !== 1'b0 || cost !== 7'd0 || lower_bound !== 10'd0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset tr=%0d cost=%0d lb=%0d rdy=%0d required all 0",
                     table_ready, cost, lower_bound, in_ready);
        end
        @(posedge clk);
        #4 rst_n = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset in_ready=%0d required=0", in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || table_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_after_reset rdy=%0d tr=%0d required 1/0", in_ready, table_ready);
        end
        for (int k = 0; k < 64; k++) ref_mem[k] = int'($urandom_range(0, 127));
        load_table(2);
        sweep();
    endtask

    initial begin
        test_reset();
        test_seq_load();
        test_lookup();
        test_toggle();
        test_row2();
        test_restart();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
